// File: rtl/ncl_mult3_pkg.sv
// rtl/ncl_mult3_pkg.sv - shared types, dual-rail codes and helpers for the NCL 3x3 multiplier adapter
package ncl_mult3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2
   } state_t;

   typedef struct packed {
      logic rail1;
      logic rail0;
   } dr_t;

   localparam int OP_W   = 3;
   localparam int PROD_W = 6;

   localparam dr_t DR_NULL    = 2'b00;
   localparam dr_t DR_ILLEGAL = 2'b11;

   function automatic dr_t encode_dr(input logic bin);
      dr_t dr;
      dr.rail1 = bin;
      dr.rail0 = ~bin;
      return dr;
   endfunction

   // Only meaningful on a legal DATA code; rail1 carries the value.
   function automatic logic decode_dr(input dr_t dr);
      return dr.rail1;
   endfunction

endpackage

// File: rtl/ncl_sync_ff.sv
// rtl/ncl_sync_ff.sv - async-reset flop chain bringing an NCL-side signal into the clk domain
module ncl_sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl_mult3_sync_adapter.sv
// rtl/ncl_mult3_sync_adapter.sv - valid/ready to DATA/NULL wavefront adapter for the NCL 3x3 multiplier
// Optional phase watchdog: NCL_ADAPT_TIMEOUT_EN.
module ncl_mult3_sync_adapter
   import ncl_mult3_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic [OP_W-1:0]   ai_rail1,
   output logic [OP_W-1:0]   ai_rail0,
   output logic [OP_W-1:0]   bi_rail1,
   output logic [OP_W-1:0]   bi_rail0,
   output logic              ki,
   input  logic              ko,
   input  logic [PROD_W-1:0] po_rail1,
   input  logic [PROD_W-1:0] po_rail0,
   output logic [1:0]        err
);

   state_t              state;
   dr_t [OP_W-1:0]      a_q, b_q, a_dr, b_dr;
   dr_t [PROD_W-1:0]    po_dr;
   logic [PROD_W-1:0]   po_bin;
   logic                complete_raw, all_null_raw, illegal_raw;
   logic                ko_s, complete_s, all_null_s;
   logic                accept, capture, rearm, advance, timeout;
   logic [1:0]          err_q;

   always_comb begin
      complete_raw = 1'b1;
      all_null_raw = 1'b1;
      illegal_raw  = 1'b0;
      for (int i = 0; i < PROD_W; i++) begin
         po_dr[i]     = {po_rail1[i], po_rail0[i]};
         po_bin[i]    = decode_dr(po_dr[i]);
         complete_raw &= (po_dr[i] != DR_NULL) && (po_dr[i] != DR_ILLEGAL);
         all_null_raw &= (po_dr[i] == DR_NULL);
         illegal_raw  |= (po_dr[i] == DR_ILLEGAL);
      end
      for (int i = 0; i < OP_W; i++) begin
         a_dr[i]     = encode_dr(in_a[i]);
         b_dr[i]     = encode_dr(in_b[i]);
         ai_rail1[i] = a_q[i].rail1;
         ai_rail0[i] = a_q[i].rail0;
         bi_rail1[i] = b_q[i].rail1;
         bi_rail0[i] = b_q[i].rail0;
      end
   end

   ncl_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_ko (
      .clk(clk), .rst_n(rst_n), .d(ko), .q(ko_s));
   ncl_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_complete (
      .clk(clk), .rst_n(rst_n), .d(complete_raw), .q(complete_s));
   ncl_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_all_null (
      .clk(clk), .rst_n(rst_n), .d(all_null_raw), .q(all_null_s));

   // Accept only when the multiplier is idle and the single output slot is free or draining.
   assign in_ready = (state == ST_IDLE) && ko_s && all_null_s && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign capture  = (state == ST_DATA) && complete_s && !ko_s;
   assign rearm    = (state == ST_NULL) && all_null_s && ko_s;
   assign advance  = accept || capture || rearm;
   assign err      = err_q;

`ifdef NCL_ADAPT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   assign timeout = (state != ST_IDLE) && !advance && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == ST_IDLE || advance || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         a_q       <= {OP_W{DR_NULL}};
         b_q       <= {OP_W{DR_NULL}};
         ki        <= 1'b1;
         out_valid <= 1'b0;
         out_p     <= '0;
         err_q     <= 2'b00;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (state == ST_DATA && illegal_raw) begin
            err_q[1] <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q   <= a_dr;
                  b_q   <= b_dr;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Rails stay stable until ki falls, so the raw product is safe once complete_s is seen.
               if (capture) begin
                  out_p     <= po_bin;
                  out_valid <= 1'b1;
                  a_q       <= {OP_W{DR_NULL}};
                  b_q       <= {OP_W{DR_NULL}};
                  ki        <= 1'b0;
                  state     <= ST_NULL;
               end
            end
            ST_NULL: begin
               if (rearm) begin
                  ki    <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (timeout) begin
            err_q[0] <= 1'b1;
            a_q      <= {OP_W{DR_NULL}};
            b_q      <= {OP_W{DR_NULL}};
            ki       <= 1'b0;
            state    <= ST_NULL;
         end
      end
   end

endmodule
